// File: rtl/madd_pipe.sv
// Pipelined multiply-add: Z = A*B +/- C or A*B + ACC, radix-4 Booth, STAGES deep, valid/ready.
// Optional saturation of results is enabled by defining MADD_PIPE_SAT_EN.
module madd_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic             FLUSH,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] Z,
   output logic             OVF
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned NDIG = (WIDTH + 2) / 2;
   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] v_in;
   logic              accept;

   logic [PW-1:0]     a_x;
   logic [WIDTH+2:0]  b_x;
   logic [PW-1:0]     pp;
   logic [PW-1:0]     prod_in;
   logic              sgn_in;

   logic [PW-1:0]     fin_prod;
   logic [WIDTH-1:0]  fin_c;
   logic [1:0]        fin_mode;
   logic              fin_sgn;
   logic [PW:0]       p_x;
   logic [PW:0]       addend;
   logic [PW:0]       sum;
   logic [WIDTH-1:0]  z_nxt;
   logic              ovf_nxt;

   logic [WIDTH-1:0]  z_q;
   logic [WIDTH-1:0]  acc_q;
   logic              ovf_q;

   // Stage k can load when it or any later stage is empty, or the output drains.
   always_comb begin
      load = '0;
      for (int k = 0; k < STAGES; k++) begin
         load[k] = OUT_READY;
         for (int j = k; j < STAGES; j++) begin
            if (!v[j]) load[k] = 1'b1;
         end
      end
   end

   assign IN_READY = load[0] & ~FLUSH;
   assign accept   = IN_VALID & IN_READY;

   always_comb begin
      v_in    = '0;
      v_in[0] = accept;
      for (int k = 1; k < STAGES; k++) v_in[k] = v[k-1];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v <= '0;
      end else if (FLUSH) begin
         v <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) v[k] <= v_in[k];
         end
      end
   end

   // Radix-4 Booth recoding of B; operands extended by one sign/zero bit pair.
   always_comb begin
      sgn_in  = (MODE != 2'b00);
      a_x     = sgn_in ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
      b_x     = {(sgn_in ? {2{B[WIDTH-1]}} : 2'b00), B, 1'b0};
      pp      = '0;
      prod_in = '0;
      for (int i = 0; i < NDIG; i++) begin
         case (b_x[2*i +: 3])
            3'b001, 3'b010: pp = a_x;
            3'b011:         pp = a_x << 1;
            3'b100:         pp = -(a_x << 1);
            3'b101, 3'b110: pp = -a_x;
            default:        pp = '0;
         endcase
         prod_in = prod_in + (pp << (2 * i));
      end
   end

   generate
      if (STAGES > 1) begin : g_mid
         logic [PW-1:0]    prod_q [STAGES-1];
         logic [WIDTH-1:0] c_q    [STAGES-1];
         logic [1:0]       mode_q [STAGES-1];

         always_ff @(posedge CLK) begin
            if (accept) begin
               prod_q[0] <= prod_in;
               c_q[0]    <= C;
               mode_q[0] <= MODE;
            end
            for (int k = 1; k < STAGES - 1; k++) begin
               if (load[k] && v_in[k]) begin
                  prod_q[k] <= prod_q[k-1];
                  c_q[k]    <= c_q[k-1];
                  mode_q[k] <= mode_q[k-1];
               end
            end
         end

         assign fin_prod = prod_q[STAGES-2];
         assign fin_c    = c_q[STAGES-2];
         assign fin_mode = mode_q[STAGES-2];
      end else begin : g_one
         assign fin_prod = prod_in;
         assign fin_c    = C;
         assign fin_mode = MODE;
      end
   endgenerate

   // Final add at 2*WIDTH+1 bits, in front of the output register.
   always_comb begin
      fin_sgn = (fin_mode != 2'b00);
      p_x     = {fin_sgn & fin_prod[PW-1], fin_prod};
      case (fin_mode)
         2'b00:   addend = {{(WIDTH+1){1'b0}}, fin_c};
         2'b11:   addend = {{(WIDTH+1){acc_q[WIDTH-1]}}, acc_q};
         default: addend = {{(WIDTH+1){fin_c[WIDTH-1]}}, fin_c};
      endcase
      sum     = (fin_mode == 2'b10) ? p_x - addend : p_x + addend;
      z_nxt   = sum[WIDTH-1:0];
      ovf_nxt = 1'b0;
`ifdef MADD_PIPE_SAT_EN
      if (fin_sgn) begin
         if (!(&sum[PW:WIDTH-1]) && (|sum[PW:WIDTH-1])) begin
            ovf_nxt = 1'b1;
            z_nxt   = sum[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else if (|sum[PW:WIDTH]) begin
         ovf_nxt = 1'b1;
         z_nxt   = '1;
      end
`endif
   end

`ifndef MADD_PIPE_SAT_EN
   logic unused_sum;
   assign unused_sum = ^sum[PW:WIDTH];
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         z_q   <= '0;
         ovf_q <= 1'b0;
         acc_q <= '0;
      end else if (FLUSH) begin
         ovf_q <= 1'b0;
         acc_q <= '0;
      end else if (load[LAST] && v_in[LAST]) begin
         z_q   <= z_nxt;
         ovf_q <= ovf_nxt;
         acc_q <= z_nxt;
      end
   end

   assign OUT_VALID = v[LAST];
   assign Z         = z_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_madd_pipe.sv
// Scoreboard bench for madd_pipe (WIDTH=32, STAGES=3); honours MADD_PIPE_SAT_EN.
module tb_madd_pipe;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 3;

   logic        CLK, RST_N, IN_VALID, IN_READY, FLUSH, OUT_VALID, OUT_READY, OVF;
   logic [1:0]  MODE;
   logic [31:0] A, B, C, Z;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_out_cyc = 0;
   int          prev_out_cyc = 0;
   int          n_out = 0;
   int          idx = 0;
   int          ca = 0;
   int          n0 = 0;
   logic        acc_seen, out_seen;
   logic        rand_bp = 1'b0;
   logic [31:0] macc, last_z;
   logic        last_ovf;
   logic [32:0] sb[$];

   madd_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .MODE(MODE),
      .A(A), .B(B), .C(C), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .Z(Z), .OVF(OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on wide signed integers, no Booth.
   task automatic model_push(input logic [1:0] m, input logic [31:0] a, b, c);
      logic signed [65:0] p, ad, s;
      logic [31:0]        z;
      logic               o;
      if (m == 2'b00) begin
         p  = $signed({34'd0, a}) * $signed({34'd0, b});
         ad = $signed({34'd0, c});
      end else begin
         p  = $signed({{34{a[31]}}, a}) * $signed({{34{b[31]}}, b});
         ad = (m == 2'b11) ? $signed({{34{macc[31]}}, macc}) : $signed({{34{c[31]}}, c});
      end
      s = (m == 2'b10) ? p - ad : p + ad;
      z = s[31:0];
      o = 1'b0;
`ifdef MADD_PIPE_SAT_EN
      if (m == 2'b00) begin
         if (s > 66'sh0FFFFFFFF) begin z = 32'hFFFFFFFF; o = 1'b1; end
      end else if (s > 66'sh07FFFFFFF) begin
         z = 32'h7FFFFFFF; o = 1'b1;
      end else if (s < -66'sh080000000) begin
         z = 32'h80000000; o = 1'b1;
      end
`endif
      sb.push_back({o, z});
      macc = z;
   endtask

   // One clock: handshakes decided at the falling edge, inputs changed just after rising edge.
   task automatic step();
      logic [32:0] e;
      @(negedge CLK);
      cyc++;
      acc_seen = IN_VALID && IN_READY && RST_N;
      out_seen = OUT_VALID && OUT_READY && RST_N && !FLUSH;
      if (acc_seen) model_push(MODE, A, B, C);
      if (FLUSH) begin
         sb.delete();
         macc = '0;
      end
      if (out_seen) begin
         check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("z", 64'(Z), 64'(e[31:0]));
            check("ovf", 64'(OVF), 64'(e[32]));
         end
         last_z       = Z;
         last_ovf     = OVF;
         prev_out_cyc = last_out_cyc;
         last_out_cyc = cyc;
         n_out++;
      end
      @(posedge CLK);
      #1;
      if (rand_bp) OUT_READY = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [1:0] m, input logic [31:0] a, b, c);
      MODE = m; A = a; B = b; C = c; IN_VALID = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (acc_seen) break;
      end
      check("accept", 64'(acc_seen), 64'd1);
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      IN_VALID = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         step();
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic load_txn(input int n);
      MODE = 2'(n % 4); A = 32'(n + 1); B = 32'(3 * n + 2); C = 32'(n);
   endtask

   initial begin
      RST_N = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
      MODE = '0; A = '0; B = '0; C = '0; macc = '0; last_z = '0; last_ovf = 1'b0;
      #12;
      check("rst_out_valid", 64'(OUT_VALID), 64'd0);
      check("rst_z", 64'(Z), 64'd0);
      check("rst_ovf", 64'(OVF), 64'd0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      step();
      check("in_ready_after_reset", 64'(IN_READY), 64'd1);

      // Unsigned wrap and latency.
      send(2'b00, 32'hFFFFFFFF, 32'd2, 32'd5);
      ca = cyc;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_seen) break;
      end
      check("latency", 64'(cyc - ca), 64'(STAGES));
`ifdef MADD_PIPE_SAT_EN
      check("t1_z", 64'(last_z), 64'hFFFFFFFF);
      check("t1_ovf", 64'(last_ovf), 64'd1);
`else
      check("t1_z", 64'(last_z), 64'h3);
      check("t1_ovf", 64'(last_ovf), 64'd0);
`endif

      // Signed add / subtract, back-to-back.
      send(2'b01, 32'hFFFFFFFD, 32'd7, 32'd1);
      send(2'b10, 32'd6, 32'd7, 32'd2);
      drain();
      check("t2_z", 64'(last_z), 64'h28);
      check("t2_b2b", 64'(last_out_cyc - prev_out_cyc), 64'd1);

      // Accumulate chain.
      send(2'b11, 32'd2, 32'd3, 32'hDEAD);
      send(2'b11, 32'd1, 32'd1, 32'hBEEF);
      drain();
      check("t3_z", 64'(last_z), 64'h2F);
      check("t3_b2b", 64'(last_out_cyc - prev_out_cyc), 64'd1);

      // Backpressure: capacity is STAGES.
      OUT_READY = 1'b0;
      idx = 0;
      load_txn(idx);
      IN_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (acc_seen) begin
            idx++;
            if (idx < 6) load_txn(idx);
            else IN_VALID = 1'b0;
         end
      end
      check("t4_accepted", 64'(idx), 64'(STAGES));
      check("t4_in_ready_low", 64'(IN_READY), 64'd0);
      check("t4_out_valid", 64'(OUT_VALID), 64'd1);
      n0 = n_out;
      OUT_READY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (idx == 6 && sb.size() == 0) break;
         step();
         if (acc_seen) begin
            idx++;
            if (idx < 6) load_txn(idx);
            else IN_VALID = 1'b0;
         end
      end
      IN_VALID = 1'b0;
      check("t4_outputs", 64'(n_out - n0), 64'd6);

      // Flush with a full pipe, input presented during flush is dropped.
      OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) send(2'b01, 32'(i + 9), 32'd3, 32'd1);
      FLUSH = 1'b1;
      IN_VALID = 1'b1;
      MODE = 2'b00; A = 32'd4; B = 32'd4; C = 32'd4;
      step();
      check("flush_in_ready", 64'(IN_READY), 64'd0);
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      check("flush_out_valid", 64'(OUT_VALID), 64'd0);
      check("flush_ovf", 64'(OVF), 64'd0);
      OUT_READY = 1'b1;
      send(2'b11, 32'd1, 32'd1, 32'd0);
      drain();
      check("t5_acc_cleared", 64'(last_z), 64'h1);

      // Asynchronous reset mid-stream.
      OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) send(2'b01, 32'd5, 32'd5, 32'd0);
      check("pre_rst_out_valid", 64'(OUT_VALID), 64'd1);
      check("pre_rst_z", 64'(Z), 64'd25);
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(OUT_VALID), 64'd0);
      check("async_rst_z", 64'(Z), 64'd0);
      sb.delete();
      macc = '0;
      @(posedge CLK);
      #1 RST_N = 1'b1;
      OUT_READY = 1'b1;
      send(2'b11, 32'd1, 32'd1, 32'd0);
      drain();
      check("t5_rst_acc_cleared", 64'(last_z), 64'h1);

      // Signed overflow case.
      send(2'b01, 32'h7FFFFFFF, 32'd2, 32'd0);
      drain();
`ifdef MADD_PIPE_SAT_EN
      check("t6_z", 64'(last_z), 64'h7FFFFFFF);
      check("t6_ovf", 64'(last_ovf), 64'd1);
`else
      check("t6_z", 64'(last_z), 64'hFFFFFFFE);
      check("t6_ovf", 64'(last_ovf), 64'd0);
`endif

      // Random traffic with random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0)
            send(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom_range(0, 40),
                 $urandom_range(0, 40));
         else
            send(2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom());
      end
      rand_bp = 1'b0;
      OUT_READY = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/madd_pipe.md
Name: madd_pipe

Overview:
- Parametrised, pipelined multiply-add unit for the Mosaic 2 functional unit. Successor to the single-cycle 32-bit MADD.
- Computes Z = A*B ± C, or A*B + previous result (accumulate), using radix-4 Booth partial products and a compressor tree spread over STAGES registered stages.
- valid/ready handshake on input and output, with per-stage bubble collapsing.

Parameters:
WIDTH, 32, operand and result width in bits (even, 8..64)
STAGES, 3, pipeline depth = latency in cycles and in-flight capacity (1..4)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  input transaction present
IN_READY  out  1  unit accepts input this cycle
MODE  in  2  00 unsigned A*B+C; 01 signed A*B+C; 10 signed A*B-C; 11 signed A*B+ACC
A  in  WIDTH  multiplicand
B  in  WIDTH  multiplier
C  in  WIDTH  addend (ignored in mode 11)
FLUSH  in  1  synchronous pipeline/accumulator clear
OUT_VALID  out  1  Z holds a valid result
OUT_READY  in  1  consumer accepts Z this cycle
Z  out  WIDTH  result
OVF  out  1  saturation occurred on this result (see Optional Feature)

Behaviour:
- Reset (RST_N low, async): all stage valid bits = 0, OUT_VALID = 0, Z = 0, OVF = 0, ACC = 0. IN_READY is 1 from the first edge after release.
- Stage k holds valid bit v[k]. The last stage is the output register driving Z/OUT_VALID/OVF.
- Stage k loads when v[k] = 0 or stage k advances. The last stage advances when OUT_READY = 1. Stage k < last advances when stage k+1 loads.
- IN_READY = stage 0 load condition. Input is accepted on IN_VALID & IN_READY.
- A stage with no incoming valid entry that loads takes a bubble (v = 0). Data regs may hold stale values when v = 0.
- Latency: a result accepted at edge n appears with OUT_VALID = 1 after edge n+STAGES-1 when there is no backpressure. Throughput is 1 per cycle.
- Capacity is exactly STAGES entries. With OUT_READY held low, IN_READY deasserts after STAGES accepts. Order is strictly preserved, with no loss or duplication.
- IN_READY depends combinationally on OUT_READY (ready chain). This is permitted; no other combinational in-to-out path is allowed.
- Arithmetic:
  - Full product is 2*WIDTH bits: signed for modes 01/10/11, unsigned for 00.
  - C is sign-extended for 01/10 and zero-extended for 00.
  - Final addition is at 2*WIDTH+1 bits. Z = low WIDTH bits (wrap) unless saturation is enabled.
- ACC:
  - Mode 11 uses ACC, added in the stage that loads the output register.
  - ACC updates to the new Z every time the output register loads a valid entry, in any mode. ACC therefore always equals the most recent result, even back-to-back.
  - ACC is not updated on bubbles.
- Multiplier/adder partitioning across stages is implementer's choice. With STAGES=1, the whole datapath sits before the output register.
- FLUSH (sync, highest priority after reset):
  - All v[k] clear, OUT_VALID = 0, ACC = 0, OVF = 0.
  - An input presented the same cycle is dropped. IN_READY is forced 0 during FLUSH.
- Simultaneous output handshake and new input on a full pipe: both occur, and occupancy stays constant.
- MODE/A/B/C/IN_VALID may change arbitrarily while IN_READY = 0 and are ignored.
- Reset asserted mid-operation: immediate clear per the reset line above. In-flight data is lost.

Optional Feature:
- Macro MADD_PIPE_SAT_EN.
- Defined:
  - Signed modes clamp the 2*WIDTH+1 result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Mode 00 clamps to [0, 2^WIDTH-1].
  - OVF = 1 with the result when clamping occurred. ACC takes the clamped value.
- Undefined: wrap-around to the low WIDTH bits; OVF tied to 0.

Test Plan:
1. WIDTH=32, STAGES=3, mode 00, A=0xFFFFFFFF, B=2, C=5 -> Z=0x00000003, OUT_VALID 2 edges after accept (latency 3 cycles incl. accept), OVF=0 without macro.
2. Mode 01, A=0xFFFFFFFD (-3), B=7, C=1 -> Z=0xFFFFFFEC. Then mode 10, A=6, B=7, C=2 -> Z=0x00000028. Issued back-to-back, results on consecutive cycles.
3. Accumulate after test 2: mode 11 A=2,B=3 -> 0x0000002E; immediately mode 11 A=1,B=1 -> 0x0000002F. Back-to-back, no stall.
4. OUT_READY=0 for 10 cycles while streaming 6 transactions -> exactly 3 accepted, IN_READY=0 thereafter. Release OUT_READY -> all 6 results emerge in order, one per cycle, none lost or duplicated.
5. FLUSH with 3 entries in flight -> OUT_VALID=0 next cycle. Next mode 11 A=1,B=1 -> Z=0x00000001 (ACC cleared). Repeat using RST_N low mid-stream -> Z=0, OUT_VALID=0 asynchronously.
6. Mode 01, A=0x7FFFFFFF, B=2, C=0 -> with MADD_PIPE_SAT_EN Z=0x7FFFFFFF, OVF=1. Without it Z=0xFFFFFFFE, OVF=0.
